// File: rtl/cpu_mem_bridge.sv
// cpu_mem_bridge
//   Memory-side neighbour of the CPU. Takes one CPU load/store/fetch request
//   (8/16/32/48-bit), splits it into 16-bit halfword beats on a req/ack bus,
//   stalls the CPU through cpu_enable until the transfer ends, and returns the
//   assembled, zero-extended read data on cpu_rdata.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   cpu_req_*         CPU request: valid, write, size (0..3 = 8/16/32/48b),
//                     byte address, LSB-aligned store data
//   cpu_enable        0 stalls the CPU
//   cpu_rdata         assembled read data, held until the next accepted request
//   cpu_misalign_err  last request was misaligned and was not performed
//   mem_req/we/addr/be/wdata  beat request towards memory
//   mem_ack/rdata     beat completion, read data valid with ack
//
// States
//   IDLE | waiting for a CPU request
//   BEAT | halfword beats in flight, mem_req high
//   DONE | one cycle, result valid, CPU released
module cpu_mem_bridge #(
  parameter int ADDR_W  = 32,
  parameter int RDATA_W = 48
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cpu_req_valid,
  input  logic               cpu_req_write,
  input  logic [1:0]         cpu_req_size,
  input  logic [ADDR_W-1:0]  cpu_req_addr,
  input  logic [RDATA_W-1:0] cpu_req_wdata,
  output logic               cpu_enable,
  output logic [RDATA_W-1:0] cpu_rdata,
  output logic               cpu_misalign_err,
  output logic               mem_req,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [1:0]         mem_be,
  output logic [15:0]        mem_wdata,
  input  logic               mem_ack,
  input  logic [15:0]        mem_rdata
);

  typedef enum logic [1:0] {IDLE, BEAT, DONE} state_t;

  state_t             state, state_nxt;
  logic               accept;
  logic               misalign;
  logic               wr_q;
  logic [1:0]         size_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [RDATA_W-1:0] wdata_q;
  logic [1:0]         k_q;
  logic [1:0]         last_k_q;
  logic [1:0]         last_k_in;
  logic [RDATA_W-1:0] rdata_q;
  logic               misalign_q;
  logic [ADDR_W-1:0]  beat_addr;

  assign misalign = (cpu_req_size != 2'd0) && cpu_req_addr[0];

  // Index of the final beat: sizes 0..3 take 1,1,2,3 beats.
  always_comb begin
    case (cpu_req_size)
      2'd2:    last_k_in = 2'd1;
      2'd3:    last_k_in = 2'd2;
      default: last_k_in = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    cpu_enable = 1'b0;
    mem_req    = 1'b0;
    case (state)
      IDLE: begin
        cpu_enable = !cpu_req_valid;
        if (cpu_req_valid) begin
          accept    = 1'b1;
          state_nxt = misalign ? DONE : BEAT;
        end
      end
      BEAT: begin
        mem_req = 1'b1;
        if (mem_ack && (k_q == last_k_q)) state_nxt = DONE;
      end
      DONE: begin
        cpu_enable = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (!rst_n) cpu_enable = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q       <= 1'b0;
      size_q     <= 2'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      k_q        <= 2'd0;
      last_k_q   <= 2'd0;
      rdata_q    <= '0;
      misalign_q <= 1'b0;
    end else if (accept) begin
      wr_q       <= cpu_req_write;
      size_q     <= cpu_req_size;
      addr_q     <= cpu_req_addr;
      wdata_q    <= cpu_req_wdata;
      k_q        <= 2'd0;
      last_k_q   <= last_k_in;
      rdata_q    <= '0;
      misalign_q <= misalign;
    end else if ((state == BEAT) && mem_ack) begin
      k_q <= k_q + 2'd1;
      if (!wr_q) begin
        if (size_q == 2'd0) begin
          rdata_q[7:0] <= addr_q[0] ? mem_rdata[15:8] : mem_rdata[7:0];
        end else begin
          case (k_q)
            2'd0:    rdata_q[15:0]  <= mem_rdata;
            2'd1:    rdata_q[31:16] <= mem_rdata;
            default: rdata_q[47:32] <= mem_rdata;
          endcase
        end
      end
    end
  end

  assign cpu_rdata        = rdata_q;
  assign cpu_misalign_err = misalign_q;

  // Beat address wraps naturally at the top of the address space.
  assign beat_addr = {addr_q[ADDR_W-1:1], 1'b0} + ADDR_W'({k_q, 1'b0});

  // Beat outputs are forced to zero outside BEAT so they read 0 after reset.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = 2'b00;
    mem_wdata = 16'h0000;
    if (mem_req) begin
      mem_we   = wr_q;
      mem_addr = beat_addr;
      if (size_q == 2'd0) begin
        mem_be    = addr_q[0] ? 2'b10 : 2'b01;
        mem_wdata = {wdata_q[7:0], wdata_q[7:0]};
      end else begin
        mem_be = 2'b11;
        case (k_q)
          2'd0:    mem_wdata = wdata_q[15:0];
          2'd1:    mem_wdata = wdata_q[31:16];
          default: mem_wdata = wdata_q[47:32];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cpu_mem_bridge.sv
module tb_cpu_mem_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req_valid;
  logic        cpu_req_write;
  logic [1:0]  cpu_req_size;
  logic [31:0] cpu_req_addr;
  logic [47:0] cpu_req_wdata;
  logic        cpu_enable;
  logic [47:0] cpu_rdata;
  logic        cpu_misalign_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [1:0]  mem_be;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;

  int checks   = 0;
  int failures = 0;

  // memory model: 0x100..0x105 hold 11..66, everything else is addr ^ 0x5A
  logic [3:0] ack_delay = 4'd0;
  logic [3:0] wait_cnt  = 4'd0;
  logic       stray_ack = 1'b0;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [31:0] t;
    t = a - 32'hFF;
    if (a >= 32'h100 && a <= 32'h105) return 8'h11 * t[7:0];
    return a[7:0] ^ 8'h5A;
  endfunction

  assign mem_ack   = (mem_req && (wait_cnt == ack_delay)) || stray_ack;
  assign mem_rdata = {mem_byte(mem_addr + 32'd1), mem_byte(mem_addr)};

  always @(posedge clk) begin
    if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 4'd1;
    else                     wait_cnt <= 4'd0;
  end

  always #5 clk = ~clk;

  cpu_mem_bridge #(.ADDR_W(32), .RDATA_W(48)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_valid(cpu_req_valid), .cpu_req_write(cpu_req_write),
    .cpu_req_size(cpu_req_size), .cpu_req_addr(cpu_req_addr),
    .cpu_req_wdata(cpu_req_wdata), .cpu_enable(cpu_enable),
    .cpu_rdata(cpu_rdata), .cpu_misalign_err(cpu_misalign_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata)
  );

  // beat log of the most recent request
  logic [31:0] b_addr [0:7];
  logic [1:0]  b_be   [0:7];
  logic [15:0] b_wd   [0:7];
  logic        b_we   [0:7];
  int          nb;
  int          req_high;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request in an IDLE cycle T, drop valid at T+1 and run until
  // cpu_enable rises (DONE). lat = cycles from T to DONE, -1 on timeout.
  task automatic do_req(input logic wr, input logic [1:0] sz,
                        input logic [31:0] a, input logic [47:0] wd,
                        output int lat);
    cpu_req_valid = 1'b1;
    cpu_req_write = wr;
    cpu_req_size  = sz;
    cpu_req_addr  = a;
    cpu_req_wdata = wd;
    #1;
    checks++;
    if (cpu_enable !== 1'b0) begin
      failures++;
      $display("FAIL stall_at_accept got=%b exp=0", cpu_enable);
    end
    nb = 0;
    req_high = 0;
    lat = -1;
    step();
    cpu_req_valid = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      #1;
      if (cpu_enable === 1'b1) begin
        lat = i;
        break;
      end
      if (mem_req === 1'b1) req_high++;
      if (mem_req === 1'b1 && mem_ack === 1'b1 && nb < 8) begin
        b_addr[nb] = mem_addr;
        b_be[nb]   = mem_be;
        b_wd[nb]   = mem_wdata;
        b_we[nb]   = mem_we;
        nb++;
      end
      step();
    end
    if (lat < 0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout got=no_done exp=done_within_40");
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cpu_req_valid = 1'b0;
    cpu_req_write = 1'b0;
    cpu_req_size  = 2'd0;
    cpu_req_addr  = 32'h0;
    cpu_req_wdata = 48'h0;
    repeat (3) step();
    checks++;
    if ({mem_req, mem_we, mem_be, cpu_enable, cpu_misalign_err} !== 6'b0 ||
        mem_addr !== 32'h0 || mem_wdata !== 16'h0 || cpu_rdata !== 48'h0) begin
      failures++;
      $display("FAIL reset_outputs got req=%b we=%b be=%b en=%b err=%b addr=%h wd=%h rd=%h exp=all_zero",
               mem_req, mem_we, mem_be, cpu_enable, cpu_misalign_err, mem_addr, mem_wdata, cpu_rdata);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (cpu_enable !== 1'b1) begin
      failures++;
      $display("FAIL idle_enable got=%b exp=1", cpu_enable);
    end
  endtask

  task automatic test_read48();
    int lat;
    ack_delay = 4'd0;
    do_req(1'b0, 2'd3, 32'h100, 48'h0, lat);
    checks++;
    if (lat != 4 || nb != 3) begin
      failures++;
      $display("FAIL read48_timing got lat=%0d beats=%0d exp lat=4 beats=3", lat, nb);
    end
    checks++;
    if (b_addr[0] !== 32'h100 || b_addr[1] !== 32'h102 || b_addr[2] !== 32'h104 ||
        b_be[0] !== 2'b11 || b_be[2] !== 2'b11 || b_we[0] !== 1'b0) begin
      failures++;
      $display("FAIL read48_beats got %h/%h/%h be=%b we=%b exp 100/102/104 be=11 we=0",
               b_addr[0], b_addr[1], b_addr[2], b_be[0], b_we[0]);
    end
    checks++;
    if (cpu_rdata !== 48'h665544332211) begin
      failures++;
      $display("FAIL read48_data got=%h exp=665544332211", cpu_rdata);
    end
    repeat (2) step();
    checks++;
    if (cpu_rdata !== 48'h665544332211 || cpu_enable !== 1'b1) begin
      failures++;
      $display("FAIL rdata_hold got=%h en=%b exp=665544332211 en=1", cpu_rdata, cpu_enable);
    end
  endtask

  task automatic test_write_byte();
    int lat;
    do_req(1'b1, 2'd0, 32'h203, 48'hAB, lat);
    checks++;
    if (lat != 2 || nb != 1 || b_addr[0] !== 32'h202 || b_be[0] !== 2'b10 ||
        b_wd[0] !== 16'hABAB || b_we[0] !== 1'b1) begin
      failures++;
      $display("FAIL write_byte got lat=%0d n=%0d addr=%h be=%b wd=%h we=%b exp 2 1 202 10 ABAB 1",
               lat, nb, b_addr[0], b_be[0], b_wd[0], b_we[0]);
    end
    checks++;
    if (cpu_rdata !== 48'h0) begin
      failures++;
      $display("FAIL write_rdata got=%h exp=0", cpu_rdata);
    end
  endtask

  // Entered in a DONE cycle: a request shown now must wait for IDLE.
  task automatic test_done_not_accepted();
    int lat;
    cpu_req_valid = 1'b1;
    cpu_req_write = 1'b0;
    cpu_req_size  = 2'd1;
    cpu_req_addr  = 32'h100;
    #1;
    checks++;
    if (cpu_enable !== 1'b1 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL done_cycle got en=%b req=%b exp en=1 req=0", cpu_enable, mem_req);
    end
    step();
    checks++;
    if (cpu_enable !== 1'b0 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL idle_accept got en=%b req=%b exp en=0 req=0", cpu_enable, mem_req);
    end
    step();
    cpu_req_valid = 1'b0;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin
      failures++;
      $display("FAIL deferred_beat got req=%b addr=%h exp req=1 addr=100", mem_req, mem_addr);
    end
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      if (cpu_enable === 1'b1) begin
        lat = i;
        break;
      end
      step();
    end
    checks++;
    if (lat != 1 || cpu_rdata !== 48'h2211) begin
      failures++;
      $display("FAIL deferred_data got lat=%0d rd=%h exp lat=1 rd=2211", lat, cpu_rdata);
    end
  endtask

  task automatic test_misalign();
    int lat;
    step();
    do_req(1'b0, 2'd2, 32'h41, 48'h0, lat);
    checks++;
    if (lat != 1 || nb != 0 || req_high != 0 || cpu_misalign_err !== 1'b1 ||
        cpu_rdata !== 48'h0) begin
      failures++;
      $display("FAIL misalign got lat=%0d req_cycles=%0d err=%b rd=%h exp 1 0 1 0",
               lat, req_high, cpu_misalign_err, cpu_rdata);
    end
  endtask

  task automatic test_wait_states();
    int lat;
    step();
    ack_delay = 4'd3;
    do_req(1'b0, 2'd2, 32'h10, 48'h0, lat);
    ack_delay = 4'd0;
    checks++;
    if (lat != 9 || req_high != 8 || nb != 2) begin
      failures++;
      $display("FAIL wait_timing got lat=%0d req_cycles=%0d beats=%0d exp 9 8 2", lat, req_high, nb);
    end
    checks++;
    if (cpu_rdata !== 48'h49484B4A || cpu_misalign_err !== 1'b0) begin
      failures++;
      $display("FAIL wait_data got=%h err=%b exp=49484B4A err=0", cpu_rdata, cpu_misalign_err);
    end
  endtask

  task automatic test_wrap();
    int lat;
    step();
    do_req(1'b0, 2'd2, 32'hFFFFFFFE, 48'h0, lat);
    checks++;
    if (nb != 2 || b_addr[0] !== 32'hFFFFFFFE || b_addr[1] !== 32'h0) begin
      failures++;
      $display("FAIL wrap_addr got n=%0d %h %h exp 2 FFFFFFFE 00000000", nb, b_addr[0], b_addr[1]);
    end
    checks++;
    if (cpu_rdata !== 48'h5B5AA5A4) begin
      failures++;
      $display("FAIL wrap_data got=%h exp=5B5AA5A4", cpu_rdata);
    end
  endtask

  task automatic test_byte_reads();
    int lat;
    step();
    do_req(1'b0, 2'd0, 32'h105, 48'h0, lat);
    checks++;
    if (cpu_rdata !== 48'h66 || b_be[0] !== 2'b10 || b_addr[0] !== 32'h104) begin
      failures++;
      $display("FAIL byte_odd got rd=%h be=%b addr=%h exp 66 10 104", cpu_rdata, b_be[0], b_addr[0]);
    end
    step();
    do_req(1'b0, 2'd0, 32'h102, 48'h0, lat);
    checks++;
    if (cpu_rdata !== 48'h33 || b_be[0] !== 2'b01) begin
      failures++;
      $display("FAIL byte_even got rd=%h be=%b exp 33 01", cpu_rdata, b_be[0]);
    end
  endtask

  task automatic test_write48();
    int lat;
    step();
    do_req(1'b1, 2'd3, 32'h300, 48'hCAFE_BEEF_1234, lat);
    checks++;
    if (nb != 3 || b_wd[0] !== 16'h1234 || b_wd[1] !== 16'hBEEF || b_wd[2] !== 16'hCAFE ||
        b_addr[2] !== 32'h304 || b_we[2] !== 1'b1) begin
      failures++;
      $display("FAIL write48 got n=%0d %h %h %h addr2=%h exp 3 1234 BEEF CAFE 304",
               nb, b_wd[0], b_wd[1], b_wd[2], b_addr[2]);
    end
  endtask

  task automatic test_stray_ack();
    step();
    stray_ack = 1'b1;
    step();
    step();
    checks++;
    if (mem_req !== 1'b0 || cpu_enable !== 1'b1) begin
      failures++;
      $display("FAIL stray_ack got req=%b en=%b exp req=0 en=1", mem_req, cpu_enable);
    end
    stray_ack = 1'b0;
  endtask

  task automatic test_reset_mid_transfer();
    int lat;
    step();
    cpu_req_valid = 1'b1;
    cpu_req_write = 1'b0;
    cpu_req_size  = 2'd3;
    cpu_req_addr  = 32'h100;
    step();
    cpu_req_valid = 1'b0;
    step();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h102) begin
      failures++;
      $display("FAIL beat1_reached got req=%b addr=%h exp req=1 addr=102", mem_req, mem_addr);
    end
    rst_n = 1'b0;
    step();
    checks++;
    if (mem_req !== 1'b0 || cpu_rdata !== 48'h0 || cpu_enable !== 1'b0) begin
      failures++;
      $display("FAIL reset_abort got req=%b rd=%h en=%b exp 0 0 0", mem_req, cpu_rdata, cpu_enable);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (cpu_enable !== 1'b1 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle got en=%b req=%b exp en=1 req=0", cpu_enable, mem_req);
    end
    do_req(1'b0, 2'd1, 32'h104, 48'h0, lat);
    checks++;
    if (lat != 2 || cpu_rdata !== 48'h6655) begin
      failures++;
      $display("FAIL post_reset_read got lat=%0d rd=%h exp 2 6655", lat, cpu_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_read48();
    test_write_byte();
    test_done_not_accepted();
    test_misalign();
    test_wait_states();
    test_wrap();
    test_byte_reads();
    test_write48();
    test_stray_ack();
    test_reset_mid_transfer();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
